// File: rtl/mac_tile_accum.sv
// Tiled matrix multiply-accumulate engine: C[MxN] += A[MxK] * B[KxN] over 1..MAX_TILES K-tiles.
// Optional build macro MAC_SAT_EN turns modular accumulation into sticky per-element saturation.
module mac_tile_accum #(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int MAX_TILES          = 4,
  parameter int ACC_WIDTH          = 2*DATA_WIDTH_INITIAL + $clog2(param_K*MAX_TILES)
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          host2block_val,
  output logic                                          host2block_rdy,
  input  logic [param_M*param_K*DATA_WIDTH_INITIAL-1:0] a_data_in_ext,
  input  logic [param_N*param_K*DATA_WIDTH_INITIAL-1:0] b_data_in_ext,
  input  logic                                          tile_last,
  input  logic                                          signed_mode,
  output logic [param_M*param_N*ACC_WIDTH-1:0]          c_data_out_ext,
  output logic                                          block2host_val,
  input  logic                                          block2host_rdy,
  output logic                                          mac_done,
  output logic [$clog2(MAX_TILES+1)-1:0]                tile_cnt
);

  localparam int DW  = DATA_WIDTH_INITIAL;
  localparam int PW  = 2*DW;
  localparam int KW  = (param_K > 1) ? $clog2(param_K) : 1;
  localparam int TCW = $clog2(MAX_TILES+1);

  if (ACC_WIDTH < 2*DATA_WIDTH_INITIAL) begin : g_acc_width_check
    $error("ACC_WIDTH must be at least 2*DATA_WIDTH_INITIAL");
  end

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    DRAIN,
    WAIT_TILE,
    DONE
  } state_t;

  state_t state, next_state;

  logic [DW-1:0]        a_m    [param_M][param_K];
  logic [DW-1:0]        b_m    [param_N][param_K];
  logic [PW-1:0]        prod_q [param_M][param_N];
  logic [ACC_WIDTH-1:0] acc_q  [param_M][param_N];
  logic [ACC_WIDTH-1:0] acc_nx [param_M][param_N];
`ifdef MAC_SAT_EN
  logic                 sat_q  [param_M][param_N];
  logic                 sat_nx [param_M][param_N];
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  logic [KW-1:0]  k_q;
  logic [TCW-1:0] tile_cnt_q;
  logic           last_q;
  logic           sm_q;
  logic           mac_done_q;
  logic           accept;
  logic           finish_job;

  // Product is truncated to 2*DW; the low bits are identical for signed and unsigned.
  function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic sm);
    if (sm) mul = PW'(signed'(a)) * PW'(signed'(b));
    else    mul = PW'(a) * PW'(b);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state     = state;
    host2block_rdy = 1'b0;
    block2host_val = 1'b0;
    accept         = 1'b0;
    finish_job     = 1'b0;
    case (state)
      IDLE, WAIT_TILE: begin
        host2block_rdy = rstn;
        if (host2block_val && rstn) begin
          accept     = 1'b1;
          next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        if (k_q == KW'(param_K-1)) next_state = DRAIN;
      end
      DRAIN: begin
        // A full tile budget ends the job even without tile_last.
        if (last_q || tile_cnt_q == TCW'(MAX_TILES)) begin
          finish_job = 1'b1;
          next_state = DONE;
        end else begin
          next_state = WAIT_TILE;
        end
      end
      DONE: begin
        block2host_val = 1'b1;
        if (block2host_rdy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next accumulator value for every element, consuming the registered product.
  always_comb begin
    logic [ACC_WIDTH-1:0] ext;
`ifdef MAC_SAT_EN
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
`endif
    for (int i = 0; i < param_M; i++) begin
      for (int j = 0; j < param_N; j++) begin
        if (sm_q) ext = ACC_WIDTH'(signed'(prod_q[i][j]));
        else      ext = ACC_WIDTH'(prod_q[i][j]);
`ifdef MAC_SAT_EN
        if (sm_q) begin
          sum = (ACC_WIDTH+1)'(signed'(acc_q[i][j])) + (ACC_WIDTH+1)'(signed'(ext));
          ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        end else begin
          sum = (ACC_WIDTH+1)'(acc_q[i][j]) + (ACC_WIDTH+1)'(ext);
          ovf = sum[ACC_WIDTH];
        end
        if (sat_q[i][j]) begin
          acc_nx[i][j] = acc_q[i][j];
          sat_nx[i][j] = 1'b1;
        end else if (ovf) begin
          sat_nx[i][j] = 1'b1;
          if (!sm_q)             acc_nx[i][j] = '1;
          else if (sum[ACC_WIDTH]) acc_nx[i][j] = SMIN;
          else                   acc_nx[i][j] = SMAX;
        end else begin
          sat_nx[i][j] = 1'b0;
          acc_nx[i][j] = sum[ACC_WIDTH-1:0];
        end
`else
        acc_nx[i][j] = acc_q[i][j] + ext;
`endif
      end
    end
  end

  // NOTE: the operand and product arrays are reset along with the accumulators so a reset
  // leaves no stale tile data that could leak into the next job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < param_M; i++)
        for (int k = 0; k < param_K; k++) a_m[i][k] <= '0;
      for (int j = 0; j < param_N; j++)
        for (int k = 0; k < param_K; k++) b_m[j][k] <= '0;
      for (int i = 0; i < param_M; i++) begin
        for (int j = 0; j < param_N; j++) begin
          prod_q[i][j] <= '0;
          acc_q[i][j]  <= '0;
`ifdef MAC_SAT_EN
          sat_q[i][j]  <= 1'b0;
`endif
        end
      end
      k_q        <= '0;
      tile_cnt_q <= '0;
      last_q     <= 1'b0;
      sm_q       <= 1'b0;
      mac_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      mac_done_q <= finish_job;
      if (accept) begin
        for (int i = 0; i < param_M; i++)
          for (int k = 0; k < param_K; k++)
            a_m[i][k] <= a_data_in_ext[(i*param_K+k)*DW +: DW];
        for (int j = 0; j < param_N; j++)
          for (int k = 0; k < param_K; k++)
            b_m[j][k] <= b_data_in_ext[(j*param_K+k)*DW +: DW];
        for (int i = 0; i < param_M; i++)
          for (int j = 0; j < param_N; j++) prod_q[i][j] <= '0;
        k_q    <= '0;
        last_q <= tile_last;
        if (state == IDLE) begin
          sm_q       <= signed_mode;
          tile_cnt_q <= TCW'(1);
        end else begin
          tile_cnt_q <= tile_cnt_q + TCW'(1);
        end
      end
      case (state)
        COMPUTE: begin
          for (int i = 0; i < param_M; i++) begin
            for (int j = 0; j < param_N; j++) begin
              prod_q[i][j] <= mul(a_m[i][k_q], b_m[j][k_q], sm_q);
              acc_q[i][j]  <= acc_nx[i][j];
`ifdef MAC_SAT_EN
              sat_q[i][j]  <= sat_nx[i][j];
`endif
            end
          end
          k_q <= k_q + KW'(1);
        end
        DRAIN: begin
          for (int i = 0; i < param_M; i++) begin
            for (int j = 0; j < param_N; j++) begin
              acc_q[i][j] <= acc_nx[i][j];
`ifdef MAC_SAT_EN
              sat_q[i][j] <= sat_nx[i][j];
`endif
            end
          end
        end
        DONE: begin
          // Leaving DONE empties the accumulators so IDLE always starts a job from zero.
          if (block2host_rdy) begin
            tile_cnt_q <= '0;
            for (int i = 0; i < param_M; i++) begin
              for (int j = 0; j < param_N; j++) begin
                acc_q[i][j] <= '0;
`ifdef MAC_SAT_EN
                sat_q[i][j] <= 1'b0;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    c_data_out_ext = '0;
    if (state == DONE) begin
      for (int i = 0; i < param_M; i++)
        for (int j = 0; j < param_N; j++)
          c_data_out_ext[(i*param_N+j)*ACC_WIDTH +: ACC_WIDTH] = acc_q[i][j];
    end
  end

  assign mac_done = mac_done_q;
  assign tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_mac_tile_accum.sv
// Bench for mac_tile_accum: default-width and 16-bit-accumulator instances driven in lockstep,
// checked against an arithmetic matrix-product reference model.
module tb_mac_tile_accum;

  localparam int M = 4, K = 4, N = 4, DW = 8, MT = 4;
  localparam int AW0 = 20, AW1 = 16;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              host2block_val = 1'b0;
  logic              tile_last = 1'b0;
  logic              signed_mode = 1'b0;
  logic              block2host_rdy = 1'b0;
  logic [M*K*DW-1:0] a_data = '0;
  logic [N*K*DW-1:0] b_data = '0;

  logic              rdy0, rdy1, val0, val1, done0, done1;
  logic [2:0]        tcnt0, tcnt1;
  logic [M*N*AW0-1:0] c0;
  logic [M*N*AW1-1:0] c1;

  mac_tile_accum dut0 (
    .clk(clk), .rstn(rstn), .host2block_val(host2block_val), .host2block_rdy(rdy0),
    .a_data_in_ext(a_data), .b_data_in_ext(b_data), .tile_last(tile_last),
    .signed_mode(signed_mode), .c_data_out_ext(c0), .block2host_val(val0),
    .block2host_rdy(block2host_rdy), .mac_done(done0), .tile_cnt(tcnt0)
  );

  mac_tile_accum #(.ACC_WIDTH(AW1)) dut1 (
    .clk(clk), .rstn(rstn), .host2block_val(host2block_val), .host2block_rdy(rdy1),
    .a_data_in_ext(a_data), .b_data_in_ext(b_data), .tile_last(tile_last),
    .signed_mode(signed_mode), .c_data_out_ext(c1), .block2host_val(val1),
    .block2host_rdy(block2host_rdy), .mac_done(done1), .tile_cnt(tcnt1)
  );

  int errors = 0;
  int checks = 0;

  // Tile images as the host would send them: A row-major, B transposed (elem j*K+k = B[k][j]).
  logic [7:0] a_t  [MT][M*K];
  logic [7:0] bt_t [MT][N*K];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C[i][j] after nt tiles, as a W-bit pattern: exact sum then wrap, or sticky clamp per step.
  function automatic longint model(input int i, input int j, input int nt, input bit sm,
                                   input int w);
    longint v = 0;
    longint umax, smax, smin, pa, pb;
    bit     st = 1'b0;
    umax = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w-1)) - 1;
    smin = -(longint'(1) << (w-1));
    for (int t = 0; t < nt; t++) begin
      for (int k = 0; k < K; k++) begin
        if (sm) begin
          pa = longint'($signed(a_t[t][i*K+k]));
          pb = longint'($signed(bt_t[t][j*K+k]));
        end else begin
          pa = longint'(a_t[t][i*K+k]);
          pb = longint'(bt_t[t][j*K+k]);
        end
        if (!st) begin
          v += pa * pb;
          if (SAT) begin
            if (!sm && v > umax)     begin v = umax; st = 1'b1; end
            else if (sm && v > smax) begin v = smax; st = 1'b1; end
            else if (sm && v < smin) begin v = smin; st = 1'b1; end
          end
        end
      end
    end
    return v & umax;
  endfunction

  task automatic fill_index();
    for (int t = 0; t < MT; t++)
      for (int e = 0; e < 16; e++) begin
        a_t[t][e]  = 8'(e);
        bt_t[t][e] = 8'((e % K) * N + e / K);
      end
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int t = 0; t < MT; t++)
      for (int e = 0; e < 16; e++) begin
        a_t[t][e]  = av;
        bt_t[t][e] = bv;
      end
  endtask

  task automatic fill_random();
    for (int t = 0; t < MT; t++)
      for (int e = 0; e < 16; e++) begin
        a_t[t][e]  = 8'($urandom_range(0, 255));
        bt_t[t][e] = 8'($urandom_range(0, 255));
      end
  endtask

  // Present one tile and wait (bounded) for the handshake.
  task automatic send_tile(input int t, input bit last, input bit sm, input string tag);
    int n = 0;
    @(negedge clk);
    for (int e = 0; e < 16; e++) begin
      a_data[e*DW +: DW] = a_t[t][e];
      b_data[e*DW +: DW] = bt_t[t][e];
    end
    tile_last      = last;
    signed_mode    = sm;
    host2block_val = 1'b1;
    while (!rdy0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_rdy_wait", tag), 64'(n < 40), 64'd1);
    if (t > 0) begin
      check($sformatf("%s_wait_tile_cnt", tag), 64'(tcnt0), 64'(t));
      check($sformatf("%s_no_early_done", tag), 64'(done0), 64'd0);
    end
    @(posedge clk);
    #1 host2block_val = 1'b0;
  endtask

  // Feed nt tiles (signed_mode flipped after the first) and check completion latency.
  task automatic do_tiles(input int nt, input bit sm, input bit no_last, input string tag);
    int n = 0;
    for (int t = 0; t < nt; t++)
      send_tile(t, !no_last && (t == nt-1), (t == 0) ? sm : !sm, $sformatf("%s_t%0d", tag, t));
    while (!done0 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check($sformatf("%s_latency", tag), 64'(n), 64'd5);
    check($sformatf("%s_done1", tag), 64'(done1), 64'd1);
  endtask

  // Check the DONE-state outputs, hold the sink off for 'stall' cycles, then release.
  task automatic finish_job(input int nt, input bit sm, input int stall, input string tag);
    check($sformatf("%s_val0", tag), 64'(val0), 64'd1);
    check($sformatf("%s_val1", tag), 64'(val1), 64'd1);
    check($sformatf("%s_tile_cnt", tag), 64'(tcnt0), 64'(nt));
    check($sformatf("%s_rdy_in_done", tag), 64'(rdy0), 64'd0);
    for (int e = 0; e < M*N; e++) begin
      check($sformatf("%s_c0[%0d]", tag, e), 64'(c0[e*AW0 +: AW0]), model(e/N, e%N, nt, sm, AW0));
      check($sformatf("%s_c1[%0d]", tag, e), 64'(c1[e*AW1 +: AW1]), model(e/N, e%N, nt, sm, AW1));
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_stall%0d_val", tag, s), 64'(val0), 64'd1);
      check($sformatf("%s_stall%0d_done", tag, s), 64'(done0), 64'd0);
      check($sformatf("%s_stall%0d_rdy", tag, s), 64'(rdy0), 64'd0);
      check($sformatf("%s_stall%0d_c15", tag, s), 64'(c0[15*AW0 +: AW0]), model(3, 3, nt, sm, AW0));
    end
    @(negedge clk);
    block2host_rdy = 1'b1;
    @(posedge clk);
    #1 block2host_rdy = 1'b0;
    check($sformatf("%s_idle_val", tag), 64'(val0), 64'd0);
    check($sformatf("%s_idle_rdy", tag), 64'(rdy0), 64'd1);
    check($sformatf("%s_idle_c", tag), 64'(c0 == '0), 64'd1);
    check($sformatf("%s_idle_cnt", tag), 64'(tcnt0), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_rdy", 64'(rdy0), 64'd0);
    check("rst_val", 64'(val0), 64'd0);
    check("rst_c", 64'(c0 == '0), 64'd1);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_cnt", 64'(tcnt0), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("post_rst_rdy", 64'(rdy0), 64'd1);

    // T1: single unsigned index tile
    fill_index();
    do_tiles(1, 1'b0, 1'b0, "t1");
    check("t1_c0_const", 64'(c0[0*AW0 +: AW0]), 64'd56);
    check("t1_c1_const", 64'(c0[1*AW0 +: AW0]), 64'd62);
    check("t1_c15_const", 64'(c0[15*AW0 +: AW0]), 64'd506);
    finish_job(1, 1'b0, 1, "t1");

    // T2: same tile twice through WAIT_TILE
    do_tiles(2, 1'b0, 1'b0, "t2");
    check("t2_c0_const", 64'(c0[0*AW0 +: AW0]), 64'd112);
    check("t2_c15_const", 64'(c0[15*AW0 +: AW0]), 64'd1012);
    finish_job(2, 1'b0, 0, "t2");

    // T3: signed -1 * 2 then the same data unsigned
    fill_const(8'hFF, 8'h02);
    do_tiles(1, 1'b1, 1'b0, "t3s");
    check("t3s_c7_const", 64'(c0[7*AW0 +: AW0]), 64'hFFFF8);
    finish_job(1, 1'b1, 0, "t3s");
    do_tiles(1, 1'b0, 1'b0, "t3u");
    check("t3u_c7_const", 64'(c0[7*AW0 +: AW0]), 64'd2040);
    finish_job(1, 1'b0, 0, "t3u");

    // T4 + T5: forced end at MAX_TILES without tile_last, then a 10-cycle sink stall
    fill_const(8'hFF, 8'hFF);
    do_tiles(4, 1'b0, 1'b1, "t4");
    check("t4_c1_const", 64'(c1[5*AW1 +: AW1]), SAT ? 64'hFFFF : 64'd57360);
    finish_job(4, 1'b0, 10, "t4");

    // T6: reset in the middle of COMPUTE
    fill_index();
    send_tile(0, 1'b1, 1'b0, "t6");
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_rdy", 64'(rdy0), 64'd0);
    check("t6_rst_val", 64'(val0), 64'd0);
    check("t6_rst_c", 64'(c0 == '0), 64'd1);
    check("t6_rst_cnt", 64'(tcnt0), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1 check($sformatf("t6_quiet%0d_done", s), 64'(done0 | val0), 64'd0);
    end
    do_tiles(1, 1'b0, 1'b0, "t6b");
    check("t6b_c0_const", 64'(c0[0*AW0 +: AW0]), 64'd56);
    finish_job(1, 1'b0, 0, "t6b");

    // Randomised jobs: tile count, signedness, data and sink stall all drawn at random
    for (int r = 0; r < 8; r++) begin
      int nt;
      bit sm, no_last;
      fill_random();
      nt      = $urandom_range(1, MT);
      sm      = 1'($urandom_range(0, 1));
      no_last = (nt == MT) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_tiles(nt, sm, no_last, $sformatf("rnd%0d", r));
      finish_job(nt, sm, $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
